// File: rtl/gelu_lane_scheduler.sv
// Round-robin dispatcher for a bank of non-pipelined GELU lanes.
// Results come back in input order, with per-lane timeout supervision and div_by_zero accounting.
module gelu_lane_scheduler #(
    parameter int unsigned W              = 32,
    parameter int unsigned NUM_LANES      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output logic                   out_dbz,
    output logic [NUM_LANES-1:0]   lane_valid_in,
    output logic [NUM_LANES*W-1:0] lane_xi,
    input  logic [NUM_LANES-1:0]   lane_valid_out,
    input  logic [NUM_LANES*W-1:0] lane_result,
    input  logic [NUM_LANES-1:0]   lane_div_by_zero,
    input  logic                   err_clr,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [CNT_W-1:0]       dbz_count
);

    localparam int unsigned PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_LANES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } lane_state_e;

    lane_state_e [NUM_LANES-1:0]        r_state;
    lane_state_e [NUM_LANES-1:0]        w_state_nxt;
    logic [PTR_W-1:0]                   r_issue_ptr;
    logic [PTR_W-1:0]                   r_retire_ptr;
    logic [NUM_LANES-1:0][TMR_W-1:0]    r_timer;
    logic [NUM_LANES-1:0][W-1:0]        r_res_data;
    logic [NUM_LANES-1:0]               r_res_dbz;
    logic [NUM_LANES-1:0]               r_lane_vin;
    logic [NUM_LANES-1:0][W-1:0]        r_lane_xi;
    logic                               r_armed;
    logic                               r_timeout_err;
    logic [CNT_W-1:0]                   r_dbz_count;

    logic                               w_issue_idle;
    logic                               w_retire_done;
    logic [W-1:0]                       w_out_data;
    logic                               w_out_dbz;
    logic                               w_accept;
    logic                               w_retire;
    logic                               w_dbz_retire;
    logic [NUM_LANES-1:0]               w_issue_sel;
    logic [NUM_LANES-1:0]               w_capture;
    logic [NUM_LANES-1:0]               w_expire;
    logic [NUM_LANES-1:0]               w_busy_vec;

    // Head-of-line views of the issue and retire lanes.
    always_comb begin
        w_issue_idle  = 1'b0;
        w_retire_done = 1'b0;
        w_out_data    = '0;
        w_out_dbz     = 1'b0;
        w_busy_vec    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_busy_vec[i] = (r_state[i] != S_IDLE);
            if (r_issue_ptr == PTR_W'(i)) begin
                w_issue_idle = (r_state[i] == S_IDLE);
            end
            if (r_retire_ptr == PTR_W'(i)) begin
                w_retire_done = (r_state[i] == S_DONE);
                w_out_data    = r_res_data[i];
                w_out_dbz     = r_res_dbz[i];
            end
        end
    end

    // r_armed keeps in_ready low while reset is asserted and for the first edge after it.
    assign in_ready      = r_armed & w_issue_idle;
    assign w_accept      = in_valid & in_ready;
    assign out_valid     = w_retire_done;
    assign out_data      = w_out_data;
    assign out_dbz       = w_out_dbz;
    assign w_retire      = w_retire_done & out_ready;
    assign w_dbz_retire  = w_retire & w_out_dbz;
    assign busy          = |w_busy_vec;
    assign lane_valid_in = r_lane_vin;
    assign lane_xi       = r_lane_xi;
    assign timeout_err   = r_timeout_err;
    assign dbz_count     = r_dbz_count;

    // Per-lane next state; a real completion beats a simultaneous timer expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_issue_sel = '0;
        w_capture   = '0;
        w_expire    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_issue_sel[i] = w_accept && (r_issue_ptr == PTR_W'(i));
            case (r_state[i])
                S_IDLE: begin
                    if (w_issue_sel[i]) begin
                        w_state_nxt[i] = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (lane_valid_out[i]) begin
                        w_state_nxt[i] = S_DONE;
                        w_capture[i]   = 1'b1;
                    end else if (r_timer[i] == TMR_LAST) begin
                        w_state_nxt[i] = S_DONE;
                        w_expire[i]    = 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_retire && (r_retire_ptr == PTR_W'(i))) begin
                        w_state_nxt[i] = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt[i] = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_state[i] <= S_IDLE;
            end
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Issue and retire pointers advance strictly round-robin, which preserves order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_ptr  <= '0;
            r_retire_ptr <= '0;
            r_armed      <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_accept) begin
                r_issue_ptr <= (r_issue_ptr == LAST_LANE) ? '0 : r_issue_ptr + PTR_W'(1);
            end
            if (w_retire) begin
                r_retire_ptr <= (r_retire_ptr == LAST_LANE) ? '0 : r_retire_ptr + PTR_W'(1);
            end
        end
    end

    // Lane operands, start pulses, busy timers and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane_vin <= '0;
            r_lane_xi  <= '0;
            r_timer    <= '0;
            r_res_data <= '0;
            r_res_dbz  <= '0;
        end else begin
            r_lane_vin <= w_issue_sel;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_issue_sel[i]) begin
                    r_lane_xi[i] <= in_data;
                    r_timer[i]   <= '0;
                end else if (r_state[i] == S_BUSY) begin
                    r_timer[i] <= r_timer[i] + TMR_W'(1);
                end
                if (w_capture[i]) begin
                    r_res_data[i] <= lane_result[i*W +: W];
                    r_res_dbz[i]  <= lane_div_by_zero[i];
                end else if (w_expire[i]) begin
                    r_res_data[i] <= '0;
                    r_res_dbz[i]  <= 1'b0;
                end
            end
        end
    end

    // Sticky timeout flag and saturating dbz counter; new events outrank err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout_err <= 1'b0;
            r_dbz_count   <= '0;
        end else begin
            if (|w_expire) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end
            if (err_clr) begin
                r_dbz_count <= w_dbz_retire ? CNT_W'(1) : '0;
            end else if (w_dbz_retire && (r_dbz_count != '1)) begin
                r_dbz_count <= r_dbz_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/gelu_lane_scheduler.md
Name: gelu_lane_scheduler

Overview:
Dispatches a stream of Q5.26 activations across NUM_LANES parallel GELU_Lane instances and returns their results in strict input order. Each lane is treated as non-pipelined: one operation in flight, variable latency. The block sits between the FFN output buffer and the GELU lane array. It provides valid/ready handshakes on both sides, per-lane timeout supervision and div_by_zero accounting.

Parameters:
W, 32, data width (Q5.26 signed)
NUM_LANES, 4, number of GELU_Lane instances driven (>=2; not required to be a power of two)
TIMEOUT_CYCLES, 64, max cycles a lane may stay busy before it is forced to complete
CNT_W, 16, width of the div_by_zero event counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input element valid
in_ready  out  1  scheduler can accept an element this cycle
in_data  in  W  input x (Q5.26)
out_valid  out  1  ordered result valid
out_ready  in  1  downstream accepts result
out_data  out  W  GELU(x) (Q5.26)
out_dbz  out  1  div_by_zero flag of this result
lane_valid_in  out  NUM_LANES  one-cycle start pulse per lane
lane_xi  out  NUM_LANES*W  per-lane operand; lane i occupies bits [i*W +: W]
lane_valid_out  in  NUM_LANES  lane completion pulse
lane_result  in  NUM_LANES*W  per-lane gelu_result
lane_div_by_zero  in  NUM_LANES  per-lane div_by_zero, sampled with lane_valid_out
err_clr  in  1  synchronous clear of timeout_err and dbz_count
busy  out  1  any lane not IDLE
timeout_err  out  1  sticky: a lane timed out
dbz_count  out  CNT_W  saturating count of retired results with out_dbz=1

Behaviour:
- Reset values: all outputs 0. Every lane state is IDLE. issue_ptr=0, retire_ptr=0. Timers are 0.
- Per-lane FSM with three states: IDLE, BUSY and DONE.
  - IDLE->BUSY on accept.
  - BUSY->DONE on lane_valid_out[i], or when the timer reaches TIMEOUT_CYCLES-1.
  - DONE->IDLE on retire.
- Issue:
  - in_ready = (state[issue_ptr]==IDLE). The signal is combinational from registered state only and does not depend on in_valid.
  - On accept (in_valid && in_ready):
    - lane_xi[issue_ptr] is registered with in_data.
    - lane_valid_in[issue_ptr]=1 for exactly the next cycle.
    - The lane goes BUSY.
    - issue_ptr advances, wrapping from NUM_LANES-1 to 0.
  - lane_xi holds its value until the next issue to that lane.
- Completion:
  - lane_valid_out[i] while BUSY captures lane_result[i] and lane_div_by_zero[i] into the lane's result register.
  - lane_valid_out[i] while IDLE or DONE is ignored. This covers stale pulses after a reset.
  - The lane timer counts every BUSY cycle, starting at 0 on the issue cycle.
  - Timeout: the lane goes DONE with result=0 and dbz=0, and timeout_err is set (sticky).
  - If lane_valid_out arrives in the same cycle the timer expires, the real result wins and timeout_err is not set.
- Retire:
  - out_valid = (state[retire_ptr]==DONE).
  - out_data and out_dbz come from that lane's result register.
  - On out_valid && out_ready: the lane goes IDLE, retire_ptr advances with wrap, and dbz_count increments if out_dbz=1. dbz_count saturates at all-ones.
  - While out_valid=1 and out_ready=0, out_data and out_dbz are held stable.
- Ordering: issue and retire are both strict round-robin, so output order equals input order regardless of per-lane latency.
- Latency: for an accept at cycle t and a lane that returns L cycles after its start pulse (pulse at t+1, lane_valid_out at t+1+L), out_valid=1 at t+2+L.
- Full condition: when all lanes are non-IDLE, in_ready=0.
  - A lane retiring in cycle c becomes IDLE at c+1.
  - in_ready can therefore reassert at c+1 at the earliest. Same-lane retire and issue never occur in one cycle.
- busy = OR over lanes of (state!=IDLE).
- err_clr clears timeout_err and dbz_count. A timeout or dbz retire in the same cycle as err_clr takes priority, leaving timeout_err=1 or dbz_count=1.
- Reset mid-operation: in-flight work is discarded, with no output and no flags. Subsequent late lane_valid_out pulses are ignored.

Test Plan:
- Single element: in_data=0x04000000 (x=1.0) with a lane model of L=12 accepted at t. Required: lane_valid_in[0] pulses at t+1 with lane_xi[0]=0x04000000; out_valid at t+14 with out_data equal to the lane's returned value; in_ready stays 1 throughout.
- Out-of-order return with 4 lanes, x={-1.0,0.5,2.0,3.0} and latencies {20,5,9,3}. Required: outputs appear in input order -1.0, 0.5, 2.0, 3.0; the first out_valid occurs at accept0+22.
- Full and backpressure: 6 elements back-to-back with out_ready=0. Required: in_ready=0 after the 4th accept; out_data is stable while stalled. Then raise out_ready. Required: in_ready=1 on the cycle after the first retire, and all 6 results are delivered in order.
- Timeout: a lane never returns with TIMEOUT_CYCLES=64. Required: out_valid with out_data=0 and out_dbz=0 64 cycles after issue; timeout_err=1. A later stray lane_valid_out is ignored. err_clr clears timeout_err.
- div_by_zero: 3 results returned with lane_div_by_zero=1, retired. Required: dbz_count=3. Force dbz_count to all-ones. Required: the next dbz retire leaves it at all-ones.
- Reset mid-flight: rst_n=0 with 3 lanes BUSY. Required: all outputs 0 and busy=0 immediately. After release, pending lane_valid_out pulses produce no out_valid. A fresh element completes normally via lane 0.
